axi_wr_responder: RTL and testbench
===================================

# axi_wr_responder

AXI3 write-channel responder (slave end) for the `msnw2axi` master port. It accepts one write burst at a time on AW/W, checks address and data byte parity, ID consistency and burst framing, and writes accepted beats to a simple synchronous memory port. It returns the B response with the captured ID. It sits in the bench and subsystem as the target memory model behind `msnw2axi`.

## Interface
- `MEM_AW`, 16: memory word-address width; `mem_addr = addr[MEM_AW+2:3]`.
- `ID_W`, 9: AXI ID width, matching the `msnw2axi` master ID.
- `clk` in 1: clock.
- `rstb` in 1: reset. Asynchronous and active-high, despite the name.
- `awaddr` in 32, `awaddr_parity` in 4, `awburst` in 2, `awid` in ID_W, `awlen` in 4, `awsize` in 3, `awvalid` in 1: write address channel.
- `awready` out 1.
- `wdata` in 64, `wdata_ecc` in 8, `wid` in ID_W, `wlast` in 1, `wstrb` in 8, `wvalid` in 1: write data channel.
- `wready` out 1.
- `bid` out ID_W, `bresp` out 2, `bvalid` out 1: response channel.
- `bready` in 1.
- `mem_we` out 1, `mem_addr` out MEM_AW, `mem_wdata` out 64, `mem_wstrb` out 8: memory write port.
- `err_cnt` out 16: count of SLVERR responses issued, saturating.

## Operation
- Parity: even per byte. Bit i must equal `^byte_i`.
  - `awaddr_parity[i]` covers `awaddr[8i+7:8i]`.
  - `wdata_ecc[i]` covers `wdata[8i+7:8i]`.
- FSM states:
  - IDLE to DATA on AW handshake. Capture addr, id, len, size and burst; set `err` if AW parity is bad, `awburst` is WRAP (2'b10) or reserved (2'b11), or `awsize > 3`.
  - DATA to RESP on the last W handshake. That is the beat where `wlast`=1 or the beat count equals `awlen+1`, whichever comes first.
  - RESP to IDLE on `bvalid && bready`.
- Each W beat:
  - Set `err` on data parity error, `wid != captured id`, or `wlast` mismatching the expected final beat.
  - Issue a memory write only while `err` is clear, and only if the beat itself is clean. The first erroneous beat and all later beats are not written.
- Address update after each beat:
  - INCR: `addr += 1 << awsize`, modulo 2^32. There is no 4 KB boundary check.
  - FIXED: `addr` is unchanged.
- `wstrb` passes through unmodified. Narrow-lane placement is the master's responsibility.
- `bid` is the captured ID. `bresp` is 2'b00 (OKAY) if `err` is clear, else 2'b10 (SLVERR).
- `err_cnt` increments by one at each SLVERR B handshake and saturates at 16'hFFFF.

## Timing
- All outputs are registered. Reset values:
  - `awready`=1.
  - `wready`=0, `bvalid`=0, `bresp`=0, `bid`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0.
  - `err_cnt`=0.
- `awready` is high only in IDLE and drops the cycle after the AW handshake. `awvalid` in DATA or RESP is stalled, never dropped.
- AW handshake at cycle T gives `wready`=1 from T+1 until the cycle after the last W handshake.
- `mem_we` pulses one cycle, in the cycle after each written W handshake. Address, data and strobe are valid with it.
- `bvalid` rises the cycle after the last W handshake. It holds with stable `bid`/`bresp` until `bready`.
- `awready` returns high the cycle after the B handshake. The minimum burst-to-burst turnaround is therefore 1 idle cycle.
- W beats presented during IDLE are not accepted (`wready`=0). Write-data-before-address is unsupported.
- Reset asserted mid-burst or mid-response: return to IDLE immediately, drop `bvalid`, discard the pending response, and issue no further memory writes. `err_cnt` clears.

## Structure
- Package `axi_wr_pkg` holds:
  - `resp_e` (OKAY/EXOKAY/SLVERR/DECERR) and `burst_e` (FIXED/INCR/WRAP).
  - The `wr_state_e` FSM enum (IDLE/DATA/RESP).
  - Function `byte_par_ok(data, par)`, parameterised over byte count.
- Sub-module `axi_byte_par_chk` (parameter NBYTES) returns a 1-bit error flag. It is instantiated twice: 4 bytes for AW, 8 bytes for W.

## Test plan
- INCR, `awaddr`=0x100, `awlen`=3, `awsize`=3, id=0x5A, clean parity:
  - 4 `mem_we` pulses at `mem_addr` 0x20, 0x21, 0x22, 0x23.
  - `bid`=0x5A, `bresp`=OKAY, `err_cnt`=0.
- FIXED, `awaddr`=0x40, `awlen`=1: 2 writes, both at `mem_addr` 0x08; OKAY.
- INCR, `awlen`=3, beat 2 with `wdata_ecc[0]` flipped:
  - Writes only for beats 0 and 1.
  - `bresp`=SLVERR, `err_cnt`=1.
- `awlen`=3 with `wlast` on beat 1: the burst ends after 2 beats, `bvalid` rises the next cycle, SLVERR. A following AW is accepted after the B handshake.
- `awburst`=WRAP with 2 beats: no `mem_we` at all, SLVERR. Separately, hold `bready`=0 for 5 cycles and check `bvalid`, `bid` and `bresp` stay stable and `awready` stays 0.
- Assert `rstb` on the second beat of a 4-beat burst:
  - Outputs return to reset values asynchronously and no further `mem_we` occurs.
  - After release, a new burst completes OKAY.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared types and helpers for the AXI3 write responder.
//   resp_e      : AXI B-channel response codes
//   burst_e     : AXI burst types
//   wr_state_e  : write FSM states
//   byte_par_ok : even per-byte parity check over the low nbytes bytes
package axi_wr_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_e;

  localparam int unsigned PAR_MAX_BYTES = 8;

  // Parity bit i must equal the XOR of byte i; bytes at or above nbytes are ignored.
  function automatic logic byte_par_ok(
    input logic [PAR_MAX_BYTES*8-1:0] data,
    input logic [PAR_MAX_BYTES-1:0]   par,
    input int unsigned                nbytes
  );
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < PAR_MAX_BYTES; i++) begin
      if (i < nbytes && par[i] != ^data[8*i +: 8]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/axi_byte_par_chk.sv
// Combinational even per-byte parity checker.
//   data : NBYTES*8-bit word
//   par  : one parity bit per byte
//   err  : high when any byte's parity bit disagrees with its XOR
module axi_byte_par_chk
  import axi_wr_pkg::*;
#(
  parameter int unsigned NBYTES = 8
) (
  input  logic [NBYTES*8-1:0] data,
  input  logic [NBYTES-1:0]   par,
  output logic                err
);

  logic [PAR_MAX_BYTES*8-1:0] data_ext;
  logic [PAR_MAX_BYTES-1:0]   par_ext;

  always_comb begin
    data_ext                = '0;
    par_ext                 = '0;
    data_ext[NBYTES*8-1:0]  = data;
    par_ext[NBYTES-1:0]     = par;
    err                     = ~byte_par_ok(data_ext, par_ext, NBYTES);
  end

endmodule

// File: rtl/axi_wr_responder.sv
// AXI3 write-channel responder (slave) acting as target memory model.
// Accepts one burst at a time, checks AW/W parity, ID and framing, writes
// clean beats to a synchronous memory port and returns B with captured ID.
//   clk, rstb                    : clock, asynchronous active-high reset
//   aw*                          : write address channel
//   w*                           : write data channel
//   bid, bresp, bvalid, bready   : write response channel
//   mem_we/addr/wdata/wstrb      : registered memory write port
//   err_cnt                      : saturating count of SLVERR handshakes
module axi_wr_responder
  import axi_wr_pkg::*;
#(
  parameter int unsigned MEM_AW = 16,
  parameter int unsigned ID_W   = 9
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awaddr_parity,
  input  logic [1:0]        awburst,
  input  logic [ID_W-1:0]   awid,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic              awvalid,
  output logic              awready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wdata_ecc,
  input  logic [ID_W-1:0]   wid,
  input  logic              wlast,
  input  logic [7:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  output logic [15:0]       err_cnt
);

  wr_state_e         state;
  logic [31:0]       addr_q;
  logic [ID_W-1:0]   id_q;
  logic [3:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [3:0]        beat_q;
  logic              err_q;

  logic aw_par_err;
  logic w_par_err;
  logic aw_bad;
  logic final_beat;
  logic beat_err;
  logic beat_done;

  axi_byte_par_chk #(.NBYTES(4)) u_aw_par (
    .data (awaddr),
    .par  (awaddr_parity),
    .err  (aw_par_err)
  );

  axi_byte_par_chk #(.NBYTES(8)) u_w_par (
    .data (wdata),
    .par  (wdata_ecc),
    .err  (w_par_err)
  );

  always_comb begin
    // awburst[1] covers both WRAP and the reserved encoding
    aw_bad     = aw_par_err | awburst[1] | (awsize > 3'd3);
    final_beat = (beat_q == len_q);
    beat_err   = w_par_err | (wid != id_q) | (wlast != final_beat);
    // Burst ends on an early wlast or when the expected count is reached
    beat_done  = wlast | final_beat;
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state     <= WR_IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= '0;
      bid       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      err_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        WR_IDLE: begin
          if (awvalid && awready) begin
            addr_q  <= awaddr;
            id_q    <= awid;
            len_q   <= awlen;
            size_q  <= awsize;
            burst_q <= awburst;
            beat_q  <= '0;
            err_q   <= aw_bad;
            awready <= 1'b0;
            wready  <= 1'b1;
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (wvalid && wready) begin
            if (!err_q && !beat_err) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr_q[MEM_AW+2:3];
              mem_wdata <= wdata;
              mem_wstrb <= wstrb;
            end
            err_q  <= err_q | beat_err;
            beat_q <= beat_q + 4'd1;
            if (burst_q != BURST_FIXED) addr_q <= addr_q + (32'd1 << size_q);
            if (beat_done) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= (err_q | beat_err) ? RESP_SLVERR : RESP_OKAY;
              state  <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= WR_IDLE;
            if (bresp == RESP_SLVERR && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_responder.sv
module tb_axi_wr_responder;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] awaddr;
  logic [3:0]  awaddr_parity;
  logic [1:0]  awburst;
  logic [8:0]  awid;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wdata_ecc;
  logic [8:0]  wid;
  logic        wlast;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [8:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [15:0] err_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } mem_t;

  typedef struct packed {
    logic [8:0] id;
    logic [1:0] resp;
  } b_t;

  mem_t exp_mem[$];
  b_t   exp_b[$];
  mem_t m;
  b_t   b;

  axi_wr_responder #(.MEM_AW(16), .ID_W(9)) dut (
    .clk           (clk),
    .rstb          (rstb),
    .awaddr        (awaddr),
    .awaddr_parity (awaddr_parity),
    .awburst       (awburst),
    .awid          (awid),
    .awlen         (awlen),
    .awsize        (awsize),
    .awvalid       (awvalid),
    .awready       (awready),
    .wdata         (wdata),
    .wdata_ecc     (wdata_ecc),
    .wid           (wid),
    .wlast         (wlast),
    .wstrb         (wstrb),
    .wvalid        (wvalid),
    .wready        (wready),
    .bid           (bid),
    .bresp         (bresp),
    .bvalid        (bvalid),
    .bready        (bready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ecc8(input logic [63:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  function automatic logic [3:0] par4(input logic [31:0] a);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^a[8*i +: 8];
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    mem_t e;
    e.addr = a; e.data = d; e.strb = s;
    exp_mem.push_back(e);
  endtask

  task automatic push_b(input logic [8:0] id, input logic [1:0] r);
    b_t e;
    e.id = id; e.resp = r;
    exp_b.push_back(e);
  endtask

  // Scoreboard monitor: every memory write and B handshake pops an expectation
  always @(negedge clk) begin
    if (!rstb) begin
      if (mem_we) begin
        tests++;
        if (exp_mem.size() == 0) begin
          fails++;
          $display("FAIL mem_we_unexpected addr=%0h data=%0h", mem_addr, mem_wdata);
        end else begin
          m = exp_mem.pop_front();
          if (mem_addr !== m.addr || mem_wdata !== m.data || mem_wstrb !== m.strb) begin
            fails++;
            $display("FAIL mem_write got a=%0h d=%0h s=%0h exp a=%0h d=%0h s=%0h",
                     mem_addr, mem_wdata, mem_wstrb, m.addr, m.data, m.strb);
          end
        end
      end
      if (bvalid && bready) begin
        tests++;
        if (exp_b.size() == 0) begin
          fails++;
          $display("FAIL b_unexpected bid=%0h bresp=%0h", bid, bresp);
        end else begin
          b = exp_b.pop_front();
          if (bid !== b.id || bresp !== b.resp) begin
            fails++;
            $display("FAIL b_resp got id=%0h resp=%0h exp id=%0h resp=%0h", bid, bresp, b.id, b.resp);
          end
        end
      end
    end
  end

  task automatic aw(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                    input logic [1:0] burst, input logic [8:0] id);
    int n = 0;
    awaddr = a; awaddr_parity = par4(a); awlen = len; awsize = size;
    awburst = burst; awid = id; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 50) begin n++; @(negedge clk); end
    if (!awready) begin
      tests++; fails++;
      $display("FAIL aw_timeout awready=%0b exp=1", awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic wbeat(input logic [63:0] d, input logic [8:0] id, input logic last,
                       input logic [7:0] flip);
    int n = 0;
    wdata = d; wdata_ecc = ecc8(d) ^ flip; wid = id; wlast = last;
    wstrb = 8'hFF; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 50) begin n++; @(negedge clk); end
    if (!wready) begin
      tests++; fails++;
      $display("FAIL w_timeout wready=%0b exp=1", wready);
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    @(negedge clk);
    while (!(bvalid && bready) && n < 50) begin n++; @(negedge clk); end
    if (!bvalid) begin
      tests++; fails++;
      $display("FAIL b_timeout bvalid=%0b exp=1", bvalid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    rstb = 1'b1; awaddr = '0; awaddr_parity = '0; awburst = '0; awid = '0;
    awlen = '0; awsize = '0; awvalid = 1'b0; wdata = '0; wdata_ecc = '0;
    wid = '0; wlast = 1'b0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_bid", bid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk); rstb = 1'b0;
    @(posedge clk); #1;

    // INCR 0x100, 4 beats of 8 bytes -> words 0x20..0x23
    for (int i = 0; i < 4; i++) push_wr(16'h20 + 16'(i), 64'h1111_0000_0000_0A00 + 64'(i), 8'hFF);
    push_b(9'h05A, 2'b00);
    aw(32'h100, 4'd3, 3'd3, 2'b01, 9'h05A);
    check("t1_wready_after_aw", wready, 1);
    check("t1_awready_low", awready, 0);
    for (int i = 0; i < 4; i++) wbeat(64'h1111_0000_0000_0A00 + 64'(i), 9'h05A, i == 3, 8'h00);
    wait_b();
    check("t1_err_cnt", err_cnt, 0);
    check("t1_awready_back", awready, 1);
    check("t1_mem_drained", exp_mem.size(), 0);

    // FIXED 0x40, 2 beats -> both at word 0x08
    push_wr(16'h08, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    push_wr(16'h08, 64'hDEAD_BEEF_0000_0002, 8'hFF);
    push_b(9'h011, 2'b00);
    aw(32'h40, 4'd1, 3'd3, 2'b00, 9'h011);
    wbeat(64'hDEAD_BEEF_0000_0001, 9'h011, 1'b0, 8'h00);
    wbeat(64'hDEAD_BEEF_0000_0002, 9'h011, 1'b1, 8'h00);
    wait_b();
    check("t2_err_cnt", err_cnt, 0);

    // Parity error on beat 2: only beats 0,1 written, SLVERR
    push_wr(16'h200, 64'hA5A5_0000_0000_0000, 8'hFF);
    push_wr(16'h201, 64'hA5A5_0000_0000_0001, 8'hFF);
    push_b(9'h033, 2'b10);
    aw(32'h1000, 4'd3, 3'd3, 2'b01, 9'h033);
    for (int i = 0; i < 4; i++)
      wbeat(64'hA5A5_0000_0000_0000 + 64'(i), 9'h033, i == 3, (i == 2) ? 8'h01 : 8'h00);
    wait_b();
    check("t3_err_cnt", err_cnt, 1);
    check("t3_mem_drained", exp_mem.size(), 0);

    // Early wlast on beat 1 of a 4-beat burst
    push_wr(16'h400, 64'h0123_4567_89AB_CDEF, 8'hFF);
    push_b(9'h044, 2'b10);
    aw(32'h2000, 4'd3, 3'd3, 2'b01, 9'h044);
    wbeat(64'h0123_4567_89AB_CDEF, 9'h044, 1'b0, 8'h00);
    wbeat(64'hFEDC_BA98_7654_3210, 9'h044, 1'b1, 8'h00);
    check("t4_bvalid_next_cycle", bvalid, 1);
    check("t4_wready_dropped", wready, 0);
    wait_b();
    check("t4_err_cnt", err_cnt, 2);
    // Following single-beat burst is accepted
    push_wr(16'h40, 64'h0000_0000_CAFE_F00D, 8'hFF);
    push_b(9'h1FF, 2'b00);
    aw(32'h200, 4'd0, 3'd3, 2'b01, 9'h1FF);
    wbeat(64'h0000_0000_CAFE_F00D, 9'h1FF, 1'b1, 8'h00);
    wait_b();
    check("t4b_err_cnt", err_cnt, 2);

    // WRAP burst: no writes, SLVERR, response held under backpressure
    bready = 1'b0;
    aw(32'h80, 4'd1, 3'd3, 2'b10, 9'h0A5);
    wbeat(64'h5555_5555_5555_5555, 9'h0A5, 1'b0, 8'h00);
    wbeat(64'h6666_6666_6666_6666, 9'h0A5, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_bvalid_hold", bvalid, 1);
      check("t5_bid_hold", bid, 9'h0A5);
      check("t5_bresp_hold", bresp, 2'b10);
      check("t5_awready_low", awready, 0);
    end
    push_b(9'h0A5, 2'b10);
    @(posedge clk); #1;
    bready = 1'b1;
    wait_b();
    check("t5_err_cnt", err_cnt, 3);

    // Reset during beat 1 of a 4-beat burst
    push_wr(16'h60, 64'h7777_0000_0000_0000, 8'hFF);
    aw(32'h300, 4'd3, 3'd3, 2'b01, 9'h077);
    wbeat(64'h7777_0000_0000_0000, 9'h077, 1'b0, 8'h00);
    wdata = 64'h7777_0000_0000_0001; wdata_ecc = ecc8(wdata); wid = 9'h077; wvalid = 1'b1;
    @(negedge clk);
    #1 rstb = 1'b1;
    #1;
    check("t6_awready", awready, 1);
    check("t6_wready", wready, 0);
    check("t6_bvalid", bvalid, 0);
    check("t6_mem_we", mem_we, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_err_cnt", err_cnt, 0);
    wvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rstb = 1'b0;
    @(posedge clk); #1;
    push_wr(16'hA0, 64'h8888_0000_0000_0000, 8'hFF);
    push_wr(16'hA1, 64'h8888_0000_0000_0001, 8'hFF);
    push_b(9'h012, 2'b00);
    aw(32'h500, 4'd1, 3'd3, 2'b01, 9'h012);
    wbeat(64'h8888_0000_0000_0000, 9'h012, 1'b0, 8'h00);
    wbeat(64'h8888_0000_0000_0001, 9'h012, 1'b1, 8'h00);
    wait_b();
    check("t6_post_err_cnt", err_cnt, 0);

    repeat (4) @(posedge clk);
    #1;
    check("final_mem_drained", exp_mem.size(), 0);
    check("final_b_drained", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
